// File: rtl/x32_to_q15.sv
// x32_to_q15: registered conversion of a 32-bit integer, signed or unsigned,
// into the 64-bit Q15 fixed-point format. The Q15 format has 16 integer bits,
// including the sign, and 48 fractional bits. Out-of-range inputs clamp
// symmetrically. The code 0x8000_0000_0000_0000 is never produced.
module x32_to_q15 (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        sign_mask,
    input  logic [31:0] x32_data,
    output logic        valid_out,
    output logic [63:0] q15_data,
    output logic        saturated
);

    localparam logic [63:0] Q15_MAX     = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] Q15_MIN_SYM = 64'h8000_0000_0000_0001;
    localparam logic [31:0] X32_NEG_LIM = 32'hFFFF_8000;

    logic [16:0] w_upper;
    logic        w_upper_zero;
    logic        w_upper_ones;
    logic        w_in_range;
    logic        w_clamp_neg;
    logic [63:0] w_q15;
    logic        w_sat;

    logic        r_valid;
    logic [63:0] r_q15;
    logic        r_sat;

    assign w_upper      = x32_data[31:15];
    assign w_upper_zero = (w_upper == '0);
    assign w_upper_ones = (w_upper == '1);

    // Select the in-range, clamped-low, or clamped-high result for the current input.
    // The upper-bit pattern of -32768 is the same as the pattern of -32767, so
    // -32768 is excluded by an explicit compare that makes it clamp symmetrically.
    always_comb begin
        w_in_range  = 1'b0;
        w_clamp_neg = 1'b0;
        if (sign_mask) begin
            w_in_range  = (w_upper_zero || w_upper_ones) && (x32_data != X32_NEG_LIM);
            w_clamp_neg = x32_data[31];
        end else begin
            w_in_range  = w_upper_zero;
        end

        w_q15 = {x32_data[15:0], 48'h0};
        w_sat = 1'b0;
        if (!w_in_range) begin
            w_sat = 1'b1;
            w_q15 = w_clamp_neg ? Q15_MIN_SYM : Q15_MAX;
        end
    end

    // Output register. Reset takes priority over a valid input.
    // When valid_in is low, the data and saturation flag hold their values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_q15   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_q15 <= w_q15;
                r_sat <= w_sat;
            end
        end
    end

    assign valid_out = r_valid;
    assign q15_data  = r_q15;
    assign saturated = r_sat;

endmodule

// File: tb/tb_x32_to_q15.sv
// tb_x32_to_q15: directed and streaming checks for x32_to_q15.
module tb_x32_to_q15;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic        sign_mask;
    logic [31:0] x32_data;
    logic        valid_out;
    logic [63:0] q15_data;
    logic        saturated;

    int unsigned n_checks;
    int unsigned n_errors;

    localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0001;

    x32_to_q15 u_dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .sign_mask (sign_mask),
        .x32_data  (x32_data),
        .valid_out (valid_out),
        .q15_data  (q15_data),
        .saturated (saturated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: compares against the integer value itself, not against bit fields.
    function automatic logic [64:0] ref_conv(input logic sm, input logic [31:0] x);
        longint v;
        logic [63:0] q;
        logic        s;
        if (sm) v = longint'($signed(x));
        else    v = longint'({32'h0, x});
        if (v > 32767) begin
            q = MAXV; s = 1'b1;
        end else if (v <= -32768) begin
            q = MINV; s = 1'b1;
        end else begin
            q = 64'(v) << 48; s = 1'b0;
        end
        return {s, q};
    endfunction

    // Apply one input with valid_in=1, then check the registered result one edge later.
    task automatic conv(input string tag, input logic sm, input logic [31:0] x,
                        input logic [63:0] exp_q, input logic exp_s);
        @(negedge clk);
        sign_mask = sm;
        x32_data  = x;
        valid_in  = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_q"},   q15_data,          exp_q);
        chk({tag, "_sat"}, {63'h0, saturated}, {63'h0, exp_s});
        chk({tag, "_vo"},  {63'h0, valid_out}, 64'h1);
    endtask

    initial begin
        logic [64:0] e;
        logic [31:0] r;
        logic [63:0] last_q;
        logic        last_s;
        logic        sm;
        logic [31:0] x;

        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        valid_in  = 1'b0;
        sign_mask = 1'b0;
        x32_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q",   q15_data,           64'h0);
        chk("rst_sat", {63'h0, saturated}, 64'h0);
        chk("rst_vo",  {63'h0, valid_out}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors
        conv("u_one",     1'b0, 32'd1,          64'h0001_0000_0000_0000, 1'b0);
        conv("s_one",     1'b1, 32'd1,          64'h0001_0000_0000_0000, 1'b0);
        conv("u_m1",      1'b0, 32'hFFFF_FFFF,  MAXV,                    1'b1);
        conv("s_m1",      1'b1, 32'hFFFF_FFFF,  64'hFFFF_0000_0000_0000, 1'b0);
        conv("u_m32768",  1'b0, 32'hFFFF_8000,  MAXV,                    1'b1);
        conv("s_m32768",  1'b1, 32'hFFFF_8000,  MINV,                    1'b1);
        conv("s_32767",   1'b1, 32'd32767,      64'h7FFF_0000_0000_0000, 1'b0);
        conv("s_32768",   1'b1, 32'd32768,      MAXV,                    1'b1);
        conv("s_m32767",  1'b1, 32'hFFFF_8001,  64'h8001_0000_0000_0000, 1'b0);
        conv("s_maxint",  1'b1, 32'h7FFF_FFFF,  MAXV,                    1'b1);
        conv("s_minint",  1'b1, 32'h8000_0000,  MINV,                    1'b1);
        conv("u_32767",   1'b0, 32'd32767,      64'h7FFF_0000_0000_0000, 1'b0);
        conv("u_32768",   1'b0, 32'd32768,      MAXV,                    1'b1);
        conv("u_zero",    1'b0, 32'd0,          64'h0,                   1'b0);

        // Streaming: 8 back-to-back inputs, each checked one edge after sampling
        last_q = '0;
        last_s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r  = $urandom;
            sm = 1'($urandom_range(0, 1));
            case (i % 4)
                0: x = r;
                1: x = {{17{r[20]}}, r[14:0]};
                2: x = r & 32'h0000_FFFF;
                default: x = {17'h1FFFF, r[14:0]};
            endcase
            e = ref_conv(sm, x);
            @(negedge clk);
            sign_mask = sm;
            x32_data  = x;
            valid_in  = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("strm%0d_q", i),   q15_data,           e[63:0]);
            chk($sformatf("strm%0d_sat", i), {63'h0, saturated}, {63'h0, e[64]});
            chk($sformatf("strm%0d_vo", i),  {63'h0, valid_out}, 64'h1);
            last_q = e[63:0];
            last_s = e[64];
        end

        // Drop valid_in and change the input data: the outputs must hold their values
        @(negedge clk);
        valid_in  = 1'b0;
        sign_mask = ~sign_mask;
        x32_data  = ~x32_data;
        @(posedge clk);
        #1;
        chk("idle_vo",  {63'h0, valid_out}, 64'h0);
        chk("idle_q",   q15_data,           last_q);
        chk("idle_sat", {63'h0, saturated}, {63'h0, last_s});

        // Establish a nonzero saturated result, then reset while valid_in is high
        conv("pre_rst", 1'b1, 32'h8000_0000, MINV, 1'b1);
        @(negedge clk);
        reset     = 1'b1;
        valid_in  = 1'b1;
        sign_mask = 1'b1;
        x32_data  = 32'd5;
        @(posedge clk);
        #1;
        chk("rstv_q",   q15_data,           64'h0);
        chk("rstv_sat", {63'h0, saturated}, 64'h0);
        chk("rstv_vo",  {63'h0, valid_out}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        conv("post_rst", 1'b1, 32'd2, 64'h0002_0000_0000_0000, 1'b0);

        @(negedge clk);
        valid_in = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
